regs_pipe: RTL and testbench

- Parametrised multi-stage pipeline register with valid tracking, runtime-selectable delay tap, stall and flush.
- Successor to the single-stage optional register used in DSP datapaths. A single instance replaces a hand-chained series of stages.
- Sits between datapath operators (pre-adder, multiplier, accumulator) to balance latency across parallel paths.

---
 rtl/regs_pipe_if.sv | 27 ++
 rtl/regs_pipe.sv | 84 ++++++++
 tb/tb_regs_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regs_pipe_if.sv
// Bundle of the regs_pipe control, data-in and tap-out signals.
// The master drives the inputs and the slave (the pipeline) drives the tap outputs.
interface regs_pipe_if #(
  parameter int LENGTH = 18,
  parameter int DEPTH  = 4
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic              clk_en;
  logic              flush;
  logic              in_valid;
  logic [LENGTH-1:0] in_signal;
  logic [SEL_W-1:0]  delay_sel;
  logic [LENGTH-1:0] out_signal;
  logic              out_valid;
  logic [SEL_W-1:0]  fill_cnt;

  modport master (
    output clk_en, flush, in_valid, in_signal, delay_sel,
    input  out_signal, out_valid, fill_cnt
  );

  modport slave (
    input  clk_en, flush, in_valid, in_signal, delay_sel,
    output out_signal, out_valid, fill_cnt
  );
endinterface

// File: rtl/regs_pipe.sv
// Multi-stage pipeline register with valid tracking, runtime tap select, stall and flush.
// Define REGS_PIPE_OUT_REG_EN to add a register after the tap mux (one extra cycle of latency).
module regs_pipe #(
  parameter int LENGTH = 18,
  parameter int DEPTH  = 4
) (
  input logic        clk,
  input logic        rst,
  regs_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [LENGTH-1:0] stage [1:DEPTH];
  logic [DEPTH:1]    v;

  // NOTE: sequential state uses non-blocking assignments so each stage reads its
  // neighbour's value from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data stages are reset on purpose, so a non-bypass tap reads 0 after rst.
      for (int i = 1; i <= DEPTH; i++) stage[i] <= '0;
      v <= '0;
    end else begin
      if (bus.clk_en) begin
        stage[1] <= bus.in_signal;
        for (int i = DEPTH; i >= 2; i--) stage[i] <= stage[i-1];
      end
      // A flush kills the incoming word too, even while stalled.
      if (bus.flush) begin
        v <= '0;
      end else if (bus.clk_en) begin
        v[1] <= bus.in_valid;
        for (int i = DEPTH; i >= 2; i--) v[i] <= v[i-1];
      end
    end
  end

  logic [SEL_W-1:0]  sel_eff;
  logic [LENGTH-1:0] tap_data;
  logic              tap_valid;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    sel_eff   = bus.delay_sel;
    tap_data  = bus.in_signal;
    tap_valid = bus.in_valid & ~bus.flush;
    if (bus.delay_sel > SEL_W'(DEPTH)) sel_eff = SEL_W'(DEPTH);
    if (sel_eff != '0) begin
      tap_data  = stage[sel_eff];
      tap_valid = v[sel_eff];
    end
  end

  logic [SEL_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 1; i <= DEPTH; i++) cnt = cnt + SEL_W'(v[i]);
  end

  assign bus.fill_cnt = cnt;

`ifdef REGS_PIPE_OUT_REG_EN
  logic [LENGTH-1:0] out_data_q;
  logic              out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.clk_en) out_data_q <= tap_data;
      if (bus.flush)       out_valid_q <= 1'b0;
      else if (bus.clk_en) out_valid_q <= tap_valid;
    end
  end

  assign bus.out_signal = out_data_q;
  assign bus.out_valid  = out_valid_q;
`else
  assign bus.out_signal = tap_data;
  assign bus.out_valid  = tap_valid;
`endif
endmodule

// File: tb/tb_regs_pipe.sv
// Self-checking bench for regs_pipe: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the delay line.
module tb_regs_pipe;
  localparam int LENGTH = 18;
  localparam int DEPTH  = 4;
  localparam int SEL_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regs_pipe_if #(.LENGTH(LENGTH), .DEPTH(DEPTH)) bus ();

  regs_pipe #(.LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Model: md[k]/mv[k] is the word accepted k+1 enabled cycles ago.
  logic [LENGTH-1:0] md[$];
  logic              mv[$];
  logic [LENGTH-1:0] m_od;
  logic              m_ov;

  task automatic model_reset();
    md = {};
    mv = {};
    repeat (DEPTH) begin
      md.push_back('0);
      mv.push_back(1'b0);
    end
    m_od = '0;
    m_ov = 1'b0;
  endtask

  task automatic tap(input logic [SEL_W-1:0] sel, input logic [LENGTH-1:0] d,
                     input logic iv, input logic fl,
                     output logic [LENGTH-1:0] td, output logic tv);
    int k;
    k = (int'(sel) > DEPTH) ? DEPTH : int'(sel);
    if (k == 0) begin
      td = d;
      tv = iv & ~fl;
    end else begin
      td = md[k-1];
      tv = mv[k-1];
    end
  endtask

  function automatic int model_fill();
    int n = 0;
    foreach (mv[i]) if (mv[i]) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic r, input logic ce, input logic fl, input logic iv,
                       input logic [LENGTH-1:0] d, input logic [SEL_W-1:0] sel);
    logic [LENGTH-1:0] td;
    logic              tv;
    logic [LENGTH-1:0] ed;
    logic              ev;
    rst           = r;
    bus.clk_en    = ce;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_signal = d;
    bus.delay_sel = sel;
    #3;
    tap(sel, d, iv, fl, td, tv);
`ifdef REGS_PIPE_OUT_REG_EN
    ed = m_od;
    ev = m_ov;
`else
    ed = td;
    ev = tv;
`endif
    check("out_signal", 32'(bus.out_signal), 32'(ed));
    check("out_valid",  32'(bus.out_valid),  32'(ev));
    check("fill_cnt",   32'(bus.fill_cnt),   32'(model_fill()));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (ce) begin
        md.push_front(d);
        mv.push_front(iv);
        void'(md.pop_back());
        void'(mv.pop_back());
        m_od = td;
      end
      if (fl) begin
        foreach (mv[i]) mv[i] = 1'b0;
        m_ov = 1'b0;
      end else if (ce) begin
        m_ov = tv;
      end
    end
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.clk_en    = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signal = '0;
    bus.delay_sel = '0;
    @(posedge clk);
    model_reset();
    #1;

    phase = "fill";
    cycle(0, 1, 0, 1, 18'h3FFFF, 3);
    cycle(0, 1, 0, 1, 18'h00001, 3);
    cycle(0, 1, 0, 1, 18'h12345, 3);
    repeat (4) cycle(0, 1, 0, 0, 18'($urandom), 3);

    phase = "stall";
    cycle(0, 1, 0, 1, 18'h54321, 2);
    cycle(0, 0, 0, 1, 18'h00002, 2);
    cycle(0, 0, 0, 1, 18'h00002, 2);
    cycle(0, 1, 0, 1, 18'h00002, 2);
    repeat (3) cycle(0, 1, 0, 0, 18'h0, 2);

    phase = "bypass";
    cycle(0, 1, 0, 1, 18'h2AAAA, 0);
    cycle(0, 0, 0, 1, 18'h15555, 0);
    cycle(0, 1, 1, 1, 18'h0ABCD, 0);

    phase = "clamp";
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 18'(i * 18'h1111 + 7), 7);

    phase = "flush";
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 18'(18'h100 + i), 4);
    cycle(0, 1, 1, 1, 18'h3CCCC, 4);
    cycle(0, 1, 0, 1, 18'h1BEEF, 2);
    repeat (3) cycle(0, 1, 0, 0, 18'h0, 2);
    cycle(0, 1, 0, 1, 18'h0F00F, 4);
    cycle(0, 0, 1, 1, 18'h0F00F, 4);
    cycle(0, 1, 0, 0, 18'h0, 4);

    phase = "tap";
    cycle(0, 1, 0, 1, 18'h0000D, 1);
    cycle(0, 1, 0, 1, 18'h0000C, 1);
    cycle(0, 1, 0, 1, 18'h0000B, 1);
    cycle(0, 1, 0, 1, 18'h0000A, 1);
    for (int s = 1; s <= 4; s++) cycle(0, 0, 0, 1, 18'h3FFFF, SEL_W'(s));
    cycle(0, 0, 0, 1, 18'h3FFFF, 1);
    phase = "reset";
    cycle(1, 1, 0, 1, 18'h22222, 2);
    cycle(0, 1, 0, 1, 18'h33333, 2);
    cycle(0, 1, 0, 0, 18'h0, 2);
    cycle(0, 1, 0, 0, 18'h0, 2);
    cycle(0, 1, 0, 0, 18'h0, 2);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), 1'($urandom),
            18'($urandom), SEL_W'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
